// File: rtl/wb_stage_pipe_pkg.sv
// Shared types and helpers for the MEM->WB pipeline boundary (wb_stage_pipe).
package wb_stage_pipe_pkg;

    localparam int unsigned WB_STAGE_DATA_W = 32;
    localparam int unsigned WB_STAGE_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_STAGE_EMPTY = 2'd0,
        WB_STAGE_MAIN  = 2'd1,
        WB_STAGE_SKID  = 2'd2
    } wb_stage_state_t;

    // Packed payload layout: {we, waddr, result, hi, lo, whilo}
    function automatic int unsigned payload_w(input int unsigned aw, input int unsigned dw);
        return 2 + aw + 3 * dw;
    endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM->WB boundary bus: mem-side offer, WB-side result, valid/ready and flush.
interface wb_stage_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic              mem_whilo;
    logic              out_valid;
    logic              out_ready;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_result;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_whilo;

    modport master (
        output flush, in_valid, mem_we, mem_waddr, mem_result, mem_hi, mem_lo, mem_whilo, out_ready,
        input  in_ready, out_valid, wb_we, wb_waddr, wb_result, wb_hi, wb_lo, wb_whilo
    );

    modport slave (
        input  flush, in_valid, mem_we, mem_waddr, mem_result, mem_hi, mem_lo, mem_whilo, out_ready,
        output in_ready, out_valid, wb_we, wb_waddr, wb_result, wb_hi, wb_lo, wb_whilo
    );
endinterface

// File: rtl/wb_stage_pipe_skid_buf.sv
// Generic valid/ready buffer: 2 entries with registered in_ready when WB_STAGE_SKID_EN
// is defined, otherwise a single register with combinational in_ready.
module skid_buf
    import wb_stage_pipe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    wb_stage_state_t state_q, state_d;
    logic [W-1:0]    main_q, main_d;
    logic            accept, transfer;

`ifdef WB_STAGE_SKID_EN
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    assign in_ready = in_ready_q;
`else
    assign in_ready = out_ready | ~out_valid;
`endif

    assign out_valid = (state_q != WB_STAGE_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef WB_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        unique case (state_q)
            WB_STAGE_EMPTY: if (accept) begin
                state_d = WB_STAGE_MAIN;
                main_d  = in_data;
            end
            WB_STAGE_MAIN: begin
`ifdef WB_STAGE_SKID_EN
                if (accept && !transfer) begin
                    state_d = WB_STAGE_SKID;
                    skid_d  = in_data;
                end else
`endif
                if (accept) main_d = in_data;
                else if (transfer) state_d = WB_STAGE_EMPTY;
            end
`ifdef WB_STAGE_SKID_EN
            WB_STAGE_SKID: if (transfer) begin
                state_d = WB_STAGE_MAIN;
                main_d  = skid_q;
            end
`endif
            default: state_d = WB_STAGE_EMPTY;
        endcase
        // Flush squashes everything, including an entry offered this cycle.
        if (flush) begin
            state_d = WB_STAGE_EMPTY;
            main_d  = '0;
`ifdef WB_STAGE_SKID_EN
            skid_d  = '0;
`endif
        end
`ifdef WB_STAGE_SKID_EN
        in_ready_d = (state_d != WB_STAGE_SKID);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_STAGE_EMPTY;
            main_q  <= '0;
`ifdef WB_STAGE_SKID_EN
            skid_q     <= '0;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef WB_STAGE_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
`endif
        end
    end
endmodule

// File: rtl/wb_stage_pipe.sv
// MEM->WB pipeline boundary with handshake and flush; write strobes gated by out_valid.
// Optional 2-entry skid buffer enabled by defining WB_STAGE_SKID_EN.
module wb_stage_pipe
    import wb_stage_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = WB_STAGE_DATA_W,
    parameter int unsigned ADDR_W = WB_STAGE_ADDR_W
) (
    input logic            clk,
    input logic            rst,
    wb_stage_pipe_if.slave bus
);
    localparam int unsigned W = payload_w(ADDR_W, DATA_W);

    logic [W-1:0] in_data, out_data;
    logic         ent_we, ent_whilo;

    assign in_data = {bus.mem_we, bus.mem_waddr, bus.mem_result, bus.mem_hi, bus.mem_lo, bus.mem_whilo};
    assign {ent_we, bus.wb_waddr, bus.wb_result, bus.wb_hi, bus.wb_lo, ent_whilo} = out_data;

    assign bus.wb_we    = bus.out_valid & ent_we;
    assign bus.wb_whilo = bus.out_valid & ent_whilo;

    skid_buf #(.W(W)) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe; covers both WB_STAGE_SKID_EN builds.
module tb_wb_stage_pipe;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] result;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          whilo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_e;

    wb_stage_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_stage_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Every handshake on the output side is checked against the oldest accepted entry.
    always @(negedge clk) begin
        if (mon_en && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_out: got waddr=%0d result=%h, required no entry", bus.wb_waddr, bus.wb_result);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.wb_we, bus.wb_waddr, bus.wb_result, bus.wb_hi, bus.wb_lo, bus.wb_whilo} !== mon_e) begin
                    miscompares++;
                    $display("FAIL out_entry: got we=%b waddr=%0d result=%h hi=%h lo=%h whilo=%b, required we=%b waddr=%0d result=%h hi=%h lo=%h whilo=%b",
                             bus.wb_we, bus.wb_waddr, bus.wb_result, bus.wb_hi, bus.wb_lo, bus.wb_whilo,
                             mon_e.we, mon_e.waddr, mon_e.result, mon_e.hi, mon_e.lo, mon_e.whilo);
                end
            end
        end
    end

    function automatic exp_t mk(input int unsigned a, input logic [DW-1:0] r);
        exp_t e;
        e.we     = 1'b1;
        e.waddr  = AW'(a);
        e.result = r;
        e.hi     = r ^ 32'hA5A5_0000;
        e.lo     = ~r;
        e.whilo  = a[0];
        return e;
    endfunction

    task automatic drive(input logic v, input exp_t e);
        bus.in_valid   = v;
        bus.mem_we     = e.we;
        bus.mem_waddr  = e.waddr;
        bus.mem_result = e.result;
        bus.mem_hi     = e.hi;
        bus.mem_lo     = e.lo;
        bus.mem_whilo  = e.whilo;
    endtask

    task automatic test_drained(input string tag);
        vectors++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drained: got pending=%0d out_valid=%b, required 0 and 0", tag, sb.size(), bus.out_valid);
        end
        sb.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.wb_we, bus.wb_whilo, bus.in_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ctrl: got out_valid=%b we=%b whilo=%b in_ready=%b, required 0 0 0 1",
                     bus.out_valid, bus.wb_we, bus.wb_whilo, bus.in_ready);
        end
        vectors++;
        if ({bus.wb_waddr, bus.wb_result, bus.wb_hi, bus.wb_lo} !== '0) begin
            miscompares++;
            $display("FAIL reset_payload: got waddr=%0d result=%h hi=%h lo=%h, required zero",
                     bus.wb_waddr, bus.wb_result, bus.wb_hi, bus.wb_lo);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_streaming;
        bus.out_ready = 1'b1;
        for (int unsigned i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1 drive(1'b1, mk(i, 32'h100 + i));
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_in_ready: got %b, required 1 (entry %0d)", bus.in_ready, i);
            end
            sb.push_back(mk(i, 32'h100 + i));
            if (i > 1) begin
                vectors++;
                if (bus.out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_gap: got out_valid=%b, required 1 (entry %0d)", bus.out_valid, i);
                end
            end
        end
        @(posedge clk);
        #1 drive(1'b0, '0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        test_drained("stream");
    endtask

`ifdef WB_STAGE_SKID_EN
    task automatic test_back_pressure;
        logic c_taken = 1'b0;
        bus.out_ready = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 drive(1'b1, mk(10 + i, 32'hA000 + i));
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_accept: got in_ready=%b, required 1 (entry %0d)", bus.in_ready, i);
            end
            sb.push_back(mk(10 + i, 32'hA000 + i));
        end
        @(posedge clk);
        #1 drive(1'b1, mk(12, 32'hA002));
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.wb_result !== 32'hA000) begin
                miscompares++;
                $display("FAIL bp_skid_full: got in_ready=%b out_valid=%b result=%h, required 0 1 0000a000",
                         bus.in_ready, bus.out_valid, bus.wb_result);
            end
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_registered_ready: got in_ready=%b, required 0", bus.in_ready);
        end
        for (int unsigned k = 0; k < 4 && !c_taken; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                sb.push_back(mk(12, 32'hA002));
                c_taken = 1'b1;
            end
        end
        vectors++;
        if (!c_taken) begin
            miscompares++;
            $display("FAIL bp_c_taken: got not accepted, required accepted within 4 cycles");
        end
        @(posedge clk);
        #1 drive(1'b0, '0);
        repeat (3) @(negedge clk);
        test_drained("bp");
    endtask
`else
    task automatic test_comb_ready;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 drive(1'b1, mk(20, 32'hC000));
        @(negedge clk);
        sb.push_back(mk(20, 32'hC000));
        @(posedge clk);
        #1 drive(1'b1, mk(21, 32'hC001));
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL comb_ready_low: got in_ready=%b out_valid=%b, required 0 1", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int unsigned i = 1; i <= 3; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1 drive(1'b1, mk(20 + i, 32'hC000 + i));
            end
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL comb_ready_high: got in_ready=%b out_valid=%b, required 1 1 (entry %0d)",
                         bus.in_ready, bus.out_valid, i);
            end
            sb.push_back(mk(20 + i, 32'hC000 + i));
        end
        @(posedge clk);
        #1 drive(1'b0, '0);
        repeat (2) @(negedge clk);
        test_drained("comb");
    endtask
`endif

    task automatic test_flush;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 drive(1'b1, mk(30, 32'hF000));
        @(negedge clk);
        sb.push_back(mk(30, 32'hF000));
`ifdef WB_STAGE_SKID_EN
        @(posedge clk);
        #1 drive(1'b1, mk(31, 32'hF001));
        @(negedge clk);
        sb.push_back(mk(31, 32'hF001));
`endif
        @(posedge clk);
        #1 drive(1'b1, mk(7, 32'hBAD0));
        bus.flush = 1'b1;
        @(posedge clk);
        // Held entries are squashed; keep flushing with an offer while empty and ready.
        #1 sb.delete();
        drive(1'b1, mk(9, 32'hBAD1));
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.wb_we, bus.wb_whilo, bus.in_ready} !== 4'b0001 || bus.wb_result !== '0) begin
            miscompares++;
            $display("FAIL flush_state: got out_valid=%b we=%b whilo=%b in_ready=%b result=%h, required 0 0 0 1 0",
                     bus.out_valid, bus.wb_we, bus.wb_whilo, bus.in_ready, bus.wb_result);
        end
        @(posedge clk);
        #1 bus.flush = 1'b0;
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop_offer: got out_valid=%b, required 0", bus.out_valid);
        end
        @(posedge clk);
        #1 drive(1'b1, mk(2, 32'h600D));
        @(negedge clk);
        sb.push_back(mk(2, 32'h600D));
        @(posedge clk);
        #1 drive(1'b0, '0);
        repeat (3) @(negedge clk);
        test_drained("flush");
    endtask

    task automatic test_hilo;
        exp_t e;
        int   whilo_cycles = 0;
        e.we     = 1'b0;
        e.waddr  = 5'd3;
        e.result = 32'h55;
        e.hi     = 32'hDEAD_0000;
        e.lo     = 32'h0000_BEEF;
        e.whilo  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 drive(1'b1, e);
        @(negedge clk);
        sb.push_back(e);
        @(posedge clk);
        #1 drive(1'b0, '0);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.wb_whilo === 1'b1) whilo_cycles++;
            vectors++;
            if (bus.wb_we !== 1'b0) begin
                miscompares++;
                $display("FAIL hilo_we: got %b, required 0 (cycle %0d)", bus.wb_we, k);
            end
        end
        vectors++;
        if (whilo_cycles != 1) begin
            miscompares++;
            $display("FAIL hilo_whilo_cycles: got %0d, required 1", whilo_cycles);
        end
        vectors++;
        if (bus.wb_hi !== 32'hDEAD_0000 || bus.wb_lo !== 32'h0000_BEEF) begin
            miscompares++;
            $display("FAIL hilo_hold: got hi=%h lo=%h, required deadbeef halves held", bus.wb_hi, bus.wb_lo);
        end
        test_drained("hilo");
    endtask

    initial begin
        test_reset();
        test_streaming();
`ifdef WB_STAGE_SKID_EN
        test_back_pressure();
`else
        test_comb_ready();
`endif
        test_flush();
        test_hilo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
